// File: rtl/alu_pkg.sv
// Shared types for the ALU command sequencer: opcodes, queued command format
// and sequencer FSM states.
package alu_pkg;

  localparam int ALU_W = 4;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    AND = 3'd2,
    OR  = 3'd3,
    XOR = 3'd4,
    NOT = 3'd5,
    SHL = 3'd6,
    SHR = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    alu_op_e          op;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_4bit.sv
// Combinational 4-bit ALU. SUB carry is the borrow out; shifts return the
// bit shifted out as carry.
module alu_4bit
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic [2:0]       op_code,
  output logic [ALU_W-1:0] result,
  output logic             carry_out,
  output logic             zero
);

  always_comb begin
    result    = '0;
    carry_out = 1'b0;
    case (alu_op_e'(op_code))
      ADD: {carry_out, result} = {1'b0, a} + {1'b0, b};
      SUB: {carry_out, result} = {1'b0, a} - {1'b0, b};
      AND: result = a & b;
      OR:  result = a | b;
      XOR: result = a ^ b;
      NOT: result = ~a;
      SHL: begin
        result    = {a[ALU_W-2:0], 1'b0};
        carry_out = a[ALU_W-1];
      end
      SHR: begin
        result    = {1'b0, a[ALU_W-1:1]};
        carry_out = a[0];
      end
      default: ;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; pushes when full and pops when empty are ignored.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  alu_cmd_t         wdata,
  input  logic             pop,
  output alu_cmd_t         rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  alu_cmd_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Queues ALU commands, issues them one at a time to a combinational ALU and
// returns the captured ALU outputs as a registered valid/ready response.
//
// state | meaning
// IDLE  | nothing in flight; ALU inputs hold last issued command
// ISSUE | ALU inputs driven for one cycle; outputs captured at closing edge
// RESP  | response held on rsp_* until rsp_ready
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter  int FIFO_DEPTH = 4,
  parameter  int DATA_W     = 4,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [2:0]        cmd_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_carry,
  output logic              rsp_zero,
  output logic [2:0]        rsp_op,
  output logic              busy,
  output logic [CNT_W-1:0]  fifo_count
);

  seq_state_e state_q;
  seq_state_e state_d;
  alu_cmd_t   fifo_wdata;
  alu_cmd_t   fifo_rdata;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_push;
  logic       fifo_pop;
  logic       rsp_load;
  logic       rsp_fire;

  assign fifo_wdata = '{a: cmd_a, b: cmd_b, op: alu_op_e'(cmd_op)};
  assign cmd_ready  = ~fifo_full;
  assign fifo_push  = cmd_valid & cmd_ready;
  assign rsp_fire   = rsp_valid & rsp_ready;

  alu_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    rsp_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        rsp_load = 1'b1;
        state_d  = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          fifo_pop = ~fifo_empty;
          state_d  = fifo_empty ? IDLE : ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ALU operands only move on a pop so the ALU sees a stable command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
    end else if (fifo_pop) begin
      alu_a  <= fifo_rdata.a;
      alu_b  <= fifo_rdata.b;
      alu_op <= fifo_rdata.op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_op     <= '0;
    end else if (rsp_load) begin
      rsp_valid  <= 1'b1;
      rsp_result <= alu_result;
      rsp_carry  <= alu_carry;
      rsp_zero   <= alu_zero;
      rsp_op     <= alu_op;
    end else if (rsp_fire) begin
      rsp_valid  <= 1'b0;
    end
  end

  assign busy = (state_q != IDLE) | (fifo_count != '0);

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Command-issue stage directly upstream of the combinational alu_4bit.
- Accepts operand/opcode commands over a valid/ready interface and queues them in a small FIFO.
- Drives one command at a time onto the ALU inputs, captures the ALU result/carry/zero one cycle later, and presents them as a registered response with valid/ready backpressure.

Parameters:
- FIFO_DEPTH, 4, command queue entries; power of 2, minimum 2.
- DATA_W, 4, operand/result width; must equal the ALU width (4).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  queue can accept a command.
- cmd_a  in  DATA_W  operand A.
- cmd_b  in  DATA_W  operand B.
- cmd_op  in  3  opcode (alu_op_e).
- alu_a  out  DATA_W  to ALU A.
- alu_b  out  DATA_W  to ALU B.
- alu_op  out  3  to ALU op_code.
- alu_result  in  DATA_W  from ALU result.
- alu_carry  in  1  from ALU carry_out.
- alu_zero  in  1  from ALU zero.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  DATA_W  captured result.
- rsp_carry  out  1  captured carry.
- rsp_zero  out  1  captured zero.
- rsp_op  out  3  opcode that produced the response.
- busy  out  1  FSM not IDLE, or FIFO non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  queued entries.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FIFO emptied; fifo_count=0; cmd_ready=1 once rst_n deasserts.
  - FSM goes to IDLE.
  - alu_a/alu_b/alu_op=0.
  - rsp_valid=0 and rsp_result/carry/zero/op=0.
  - busy=0.
  - Any in-flight command or pending response is discarded.
- Push: cmd_valid & cmd_ready at an edge writes {a,b,op}.
  - cmd_ready = (fifo_count < FIFO_DEPTH). It is registered-count based and is not combinationally dependent on a same-cycle pop.
- Pop: performed by the FSM only.
  - Simultaneous push and pop leaves fifo_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states IDLE, ISSUE, RESP:
  - IDLE: if FIFO non-empty, pop the head into the alu_a/alu_b/alu_op registers and go to ISSUE; otherwise stay.
  - ISSUE (exactly 1 cycle): ALU inputs are stable for the full cycle. At the closing edge, capture alu_result/carry/zero and alu_op into the rsp_* registers, set rsp_valid=1, and go to RESP.
  - RESP: rsp_valid=1 and rsp_* held stable until rsp_ready=1.
    - On handshake with FIFO non-empty: pop the next command into the ALU regs and go to ISSUE; rsp_valid drops for that cycle.
    - On handshake with FIFO empty: rsp_valid=0 and go to IDLE.
- ALU inputs: alu_a/alu_b/alu_op hold their last issued values while in IDLE and RESP. They change only on a pop edge.
- Latency: with the queue empty, a command accepted at edge E0 is popped at E1 and captured at E2. rsp_valid is high after E2, i.e. 2 cycles.
- Throughput: with rsp_ready held at 1, one response every 2 cycles.
- Result semantics: the sequencer does no arithmetic; it captures the ALU outputs unmodified. Width and carry rules are the ALU's.
- Response backpressure: with rsp_ready=0 indefinitely, the FIFO fills to FIFO_DEPTH and cmd_ready goes low. No command is dropped or overwritten.
- busy = (state != IDLE) | (fifo_count != 0).

Decomposition:
- Package alu_pkg:
  - alu_op_e enum: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOT=5, SHL=6, SHR=7.
  - ALU_W=4.
  - alu_cmd_t packed struct {a, b, op}.
  - seq_state_e {IDLE, ISSUE, RESP}.
- Sub-module alu_cmd_fifo: synchronous FIFO of alu_cmd_t with push/pop/full/empty/count and async active-low reset.
- The FSM and response registers live in alu_op_sequencer.
- The bench connects alu_op_sequencer to a real alu_4bit.

Test Plan:
- Reset mid-RESP with a response pending and 2 entries queued: rst_n pulsed low asynchronously between edges -> rsp_valid=0, fifo_count=0, alu_a/alu_b/alu_op=0 immediately; no response appears after release.
- Single ADD, A=5, B=3, rsp_ready=1: accept at E0 -> rsp_valid rises after E2 with rsp_result=8, rsp_zero=0, rsp_op=ADD.
- SUB, A=3, B=3 -> rsp_result=0, rsp_zero=1. Then NOT, A=5 -> rsp_result=4'b1010, rsp_zero=0. Responses arrive in command order.
- ADD, A=9, B=8 -> rsp_result=1, rsp_carry=1. Verifies carry capture and 4-bit wrap.
- Backpressure, rsp_ready=0, 6 back-to-back commands:
  - 1st command is captured; the next 4 fill the FIFO (fifo_count=4); cmd_ready=0; the 6th command stalls.
  - Raising rsp_ready drains all 6 in order, one response per 2 cycles; the 6th command is accepted on the first pop.
- Streaming all 8 opcodes, A=5, B=3, rsp_ready=1, cmd_valid held high:
  - Expected results: 8, 2, 1, 7, 6, 10, 10, 2.
  - rsp_valid toggles every cycle; busy falls 1 cycle after the last response handshake.
